// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
//
// Control sequencer for an FIR datapath built from an addressable shift
// register (ASR) and a multiply-accumulate unit (MAC). For every input
// sample it:
//   1. accepts the sample and pulses the ASR shift enable,
//   2. sweeps the tap and coefficient address over all N_TAPS taps while
//      driving MAC clear (first tap) and accumulate enable,
//   3. waits MAC_LAT cycles for the MAC pipeline to drain,
//   4. presents the finished result until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source holding valid=1 must keep it (and its data) stable
// until that edge. in_ready does not depend on in_valid. out_valid, once
// raised, stays high until the edge where out_ready=1.
//
// Ports
//   clk        rising-edge clock
//   clr        synchronous reset, active high; masks all strobes while high
//   in_valid   sample present on the ASR d bus
//   in_ready   sequencer can accept a sample (IDLE only)
//   asr_en     ASR shift enable; the ASR captures d on this edge
//   asr_add    ASR tap select, 0 = newest sample; holds outside RUN
//   coef_add   coefficient ROM address, always equal to asr_add
//   mac_clr    MAC loads the product instead of accumulating (first tap)
//   mac_en     MAC product/accumulate enable
//   out_valid  MAC output holds a complete result
//   out_ready  consumer takes the result
//   warm       fewer than N_TAPS samples accepted since reset
//   busy       sequencer is not IDLE
//   state_dbg  current FSM state (IDLE=0, RUN=1, WAIT=2, DONE=3)
// ---------------------------------------------------------------------------
module fir_tap_sequencer #(
    parameter int N_TAPS  = 16,
    parameter int MAC_LAT = 1
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      asr_en,
    output logic [$clog2(N_TAPS)-1:0] asr_add,
    output logic [$clog2(N_TAPS)-1:0] coef_add,
    output logic                      mac_clr,
    output logic                      mac_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      warm,
    output logic                      busy,
    output logic [1:0]                state_dbg
);

    localparam int AW = $clog2(N_TAPS);
    localparam int FW = $clog2(N_TAPS + 1);

    localparam logic [AW-1:0] TAP_LAST = AW'(N_TAPS - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(N_TAPS);

    // WAIT is never entered when MAC_LAT is 0, so its terminal value is moot.
    localparam int            LAT_LAST_I = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;
    localparam logic [2:0]    LAT_LAST   = LAT_LAST_I[2:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  tap_q,   tap_d;
    logic [2:0]     lat_q,   lat_d;
    logic [FW-1:0]  fill_q,  fill_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            tap_q   <= '0;
            lat_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            lat_q   <= lat_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        lat_d     = lat_q;
        fill_d    = fill_q;
        in_ready  = 1'b0;
        asr_en    = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                asr_en   = in_valid;
                if (in_valid) begin
                    state_d = RUN;
                    tap_d   = '0;
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            RUN: begin
                mac_en  = 1'b1;
                mac_clr = (tap_q == '0);
                // Terminal compare rather than wrap, so non-power-of-2 tap
                // counts never address past N_TAPS-1. tap stays at the last
                // tap so the address bus holds its final value.
                if (tap_q == TAP_LAST) begin
                    lat_d   = '0;
                    state_d = (MAC_LAT == 0) ? DONE : WAIT;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = DONE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset masks every strobe in the cycle it is applied, whatever the
        // state, so an in-flight sample can never leak a result.
        if (clr) begin
            in_ready  = 1'b0;
            asr_en    = 1'b0;
            mac_en    = 1'b0;
            mac_clr   = 1'b0;
            out_valid = 1'b0;
        end
    end

    assign asr_add   = tap_q;
    assign coef_add  = tap_q;
    assign warm      = (fill_q < FILL_MAX);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer
//
// Four sequencers share one clock and one stimulus stream:
//   inst 0: N_TAPS=16, MAC_LAT=1
//   inst 1: N_TAPS=16, MAC_LAT=0
//   inst 2: N_TAPS=16, MAC_LAT=3
//   inst 3: N_TAPS=5,  MAC_LAT=1
// Each instance is checked every cycle against a model that tracks only
// "idle, or how many cycles since the sample was accepted", and against
// literal latency/period values worked out by hand.
// ---------------------------------------------------------------------------
module tb_fir_tap_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr       = 1'b1;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    bit   stream_ph = 1'b0;

    // ---------------- DUT outputs ----------------
    logic       ir0, ae0, mc0, me0, ov0, wm0, bz0;
    logic [3:0] add0, cadd0;
    logic [1:0] st0;
    logic       ir1, ae1, mc1, me1, ov1, wm1, bz1;
    logic [3:0] add1, cadd1;
    logic [1:0] st1;
    logic       ir2, ae2, mc2, me2, ov2, wm2, bz2;
    logic [3:0] add2, cadd2;
    logic [1:0] st2;
    logic       ir3, ae3, mc3, me3, ov3, wm3, bz3;
    logic [2:0] add3, cadd3;
    logic [1:0] st3;

    fir_tap_sequencer #(.N_TAPS(16), .MAC_LAT(1)) u0 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ir0), .asr_en(ae0),
        .asr_add(add0), .coef_add(cadd0), .mac_clr(mc0), .mac_en(me0),
        .out_valid(ov0), .out_ready(out_ready), .warm(wm0), .busy(bz0), .state_dbg(st0));
    fir_tap_sequencer #(.N_TAPS(16), .MAC_LAT(0)) u1 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ir1), .asr_en(ae1),
        .asr_add(add1), .coef_add(cadd1), .mac_clr(mc1), .mac_en(me1),
        .out_valid(ov1), .out_ready(out_ready), .warm(wm1), .busy(bz1), .state_dbg(st1));
    fir_tap_sequencer #(.N_TAPS(16), .MAC_LAT(3)) u2 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ir2), .asr_en(ae2),
        .asr_add(add2), .coef_add(cadd2), .mac_clr(mc2), .mac_en(me2),
        .out_valid(ov2), .out_ready(out_ready), .warm(wm2), .busy(bz2), .state_dbg(st2));
    fir_tap_sequencer #(.N_TAPS(5), .MAC_LAT(1)) u3 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ir3), .asr_en(ae3),
        .asr_add(add3), .coef_add(cadd3), .mac_clr(mc3), .mac_en(me3),
        .out_valid(ov3), .out_ready(out_ready), .warm(wm3), .busy(bz3), .state_dbg(st3));

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int n_of    [4] = '{16, 16, 16, 5};
    int l_of    [4] = '{1, 0, 3, 1};
    // Hand-computed: accept to first out_valid = N+L+1, back-to-back period = N+L+2.
    int lat_lit [4] = '{18, 17, 20, 7};
    int per_lit [4] = '{19, 18, 21, 8};

    bit m_valid  [4] = '{default: 1'b0};
    bit m_idle   [4] = '{default: 1'b1};
    int m_age    [4] = '{default: 0};
    int m_acc    [4] = '{default: 0};
    int m_last   [4] = '{default: 0};
    int m_accc   [4] = '{default: 0};
    bit m_pstrm  [4] = '{default: 1'b0};
    bit m_ovp    [4] = '{default: 1'b0};

    task automatic chk(input string name, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, i, cyc, act, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic ir, input logic ae, input int add,
                              input int cadd, input logic mc, input logic me, input logic ov,
                              input logic wm, input logic bz, input int st);
        int  n;
        int  l;
        bit  in_run;
        bit  in_done;
        int  e_add;
        n = n_of[i];
        l = l_of[i];
        in_run  = !m_idle[i] && (m_age[i] <= n);
        in_done = !m_idle[i] && (m_age[i] >= n + l + 1);
        if (m_valid[i]) begin
            e_add = in_run ? m_age[i] - 1 : m_last[i];
            chk("in_ready",  i, int'(ir), int'(m_idle[i] && !clr));
            chk("asr_en",    i, int'(ae), int'(m_idle[i] && !clr && in_valid));
            chk("mac_en",    i, int'(me), int'(in_run && !clr));
            chk("mac_clr",   i, int'(mc), int'(in_run && !clr && m_age[i] == 1));
            chk("out_valid", i, int'(ov), int'(in_done && !clr));
            chk("busy",      i, int'(bz), int'(!m_idle[i]));
            chk("warm",      i, int'(wm), int'(m_acc[i] < n));
            chk("asr_add",   i, add,      e_add);
            chk("coef_add",  i, cadd,     e_add);
            chk("state_idle", i, int'(st == 0), int'(m_idle[i]));
            if (ae) begin
                if (stream_ph && m_pstrm[i]) chk("period", i, cyc - m_accc[i], per_lit[i]);
                m_accc[i]  = cyc;
                m_pstrm[i] = stream_ph;
            end
            if (ov && !m_ovp[i]) chk("latency", i, cyc - m_accc[i], lat_lit[i]);
            m_ovp[i] = ov;
            if (in_run) m_last[i] = m_age[i] - 1;
        end
        // Advance the model to the next rising edge using the current inputs.
        if (clr) begin
            m_valid[i] = 1'b1;
            m_idle[i]  = 1'b1;
            m_age[i]   = 0;
            m_acc[i]   = 0;
            m_last[i]  = 0;
        end else if (m_valid[i]) begin
            if (m_idle[i]) begin
                if (in_valid) begin
                    m_idle[i] = 1'b0;
                    m_age[i]  = 1;
                    if (m_acc[i] < n) m_acc[i]++;
                end
            end else if (in_done) begin
                if (out_ready) m_idle[i] = 1'b1;
            end else begin
                m_age[i]++;
            end
        end
    endtask

    // Single compare process, sampling away from the active edge.
    always @(negedge clk) begin
        cyc++;
        check_inst(0, ir0, ae0, int'(add0), int'(cadd0), mc0, me0, ov0, wm0, bz0, int'(st0));
        check_inst(1, ir1, ae1, int'(add1), int'(cadd1), mc1, me1, ov1, wm1, bz1, int'(st1));
        check_inst(2, ir2, ae2, int'(add2), int'(cadd2), mc2, me2, ov2, wm2, bz2, int'(st2));
        check_inst(3, ir3, ae3, int'(add3), int'(cadd3), mc3, me3, ov3, wm3, bz3, int'(st3));
    end

    // ---------------- driver ----------------
    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset for two edges.
        tick(2);
        clr = 1'b0;
        tick(2);

        // Single sample, result held with out_ready low; a sample offered
        // during DONE must not be taken.
        in_valid = 1'b1;
        tick(1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick(18);
        in_valid = 1'b1;
        tick(6);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(3);

        // Back-to-back streaming; long enough for 16+ acceptances.
        stream_ph = 1'b1;
        in_valid  = 1'b1;
        tick(320);
        stream_ph = 1'b0;
        in_valid  = 1'b0;
        tick(30);

        // Reset in the middle of RUN (tap 7 of the 16-tap instances).
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(7);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
